// File: rtl/modulator.sv
// Photonic link modulator: transmit FIFO, laser power FSM (OFF/WARMUP/ACTIVE) and a
// fixed-latency modulation pipeline. Define MODULATOR_STATS_EN to build the tx_count counter.
package modulator_pkg;
    typedef logic [31:0] packet_t;
endpackage

// Handshake: a packet transfers on a posedge where in_valid && in_ready; in_ready is
// derived only from registered FIFO occupancy (and reset), never from in_valid.
module modulator
    import modulator_pkg::*;
#(
    parameter int DELAY         = 2,
    parameter int FIFO_DEPTH    = 4,
    parameter int WARMUP_CYCLES = 3,
    parameter int IDLE_TIMEOUT  = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  packet_t       in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output packet_t       out_data,
    output logic          out_valid,
    output logic          laser_on,
    output logic [15:0]   tx_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(WARMUP_CYCLES + 1);
    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    typedef enum logic [1:0] {ST_OFF, ST_WARMUP, ST_ACTIVE} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    packet_t         r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [WW-1:0]   r_warm_cnt;
    logic [WW-1:0]   w_warm_nxt;
    logic [IW-1:0]   r_idle_cnt;
    logic [IW-1:0]   w_idle_nxt;
    packet_t         r_pipe_data [DELAY];
    logic [DELAY-1:0] r_pipe_vld;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_busy;

    assign w_full   = (r_count == CW'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = rst && !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = (r_state == ST_ACTIVE) && !w_empty;
    assign w_busy   = |r_pipe_vld;

    always_comb begin
        w_state_nxt = r_state;
        w_warm_nxt  = r_warm_cnt;
        w_idle_nxt  = '0;
        case (r_state)
            ST_OFF: begin
                if (w_push || !w_empty) begin
                    w_state_nxt = ST_WARMUP;
                    w_warm_nxt  = WW'(WARMUP_CYCLES);
                end
            end
            ST_WARMUP: begin
                if (r_warm_cnt == WW'(1)) begin
                    w_state_nxt = ST_ACTIVE;
                    w_warm_nxt  = '0;
                end else begin
                    w_warm_nxt = r_warm_cnt - WW'(1);
                end
            end
            ST_ACTIVE: begin
                // Shut down on the edge where the idle count would reach the timeout.
                if (w_empty && !w_push && !w_busy) begin
                    if (r_idle_cnt == IW'(IDLE_TIMEOUT - 1)) begin
                        w_state_nxt = ST_OFF;
                    end else begin
                        w_idle_nxt = r_idle_cnt + IW'(1);
                    end
                end
            end
            default: w_state_nxt = ST_OFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_OFF;
            r_warm_cnt <= '0;
            r_idle_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_warm_cnt <= w_warm_nxt;
            r_idle_cnt <= w_idle_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Stage data is forced to zero when empty so out_data needs no output mux.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < DELAY; i++) r_pipe_data[i] <= '0;
        end else begin
            r_pipe_vld[0]  <= w_pop;
            r_pipe_data[0] <= w_pop ? r_mem[r_rd_ptr] : '0;
            for (int i = 1; i < DELAY; i++) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_data[i] <= r_pipe_data[i-1];
            end
        end
    end

    assign out_valid = r_pipe_vld[DELAY-1];
    assign out_data  = r_pipe_data[DELAY-1];
    assign laser_on  = (r_state != ST_OFF);

`ifdef MODULATOR_STATS_EN
    logic [15:0] r_tx_count;
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_count <= '0;
        end else if (out_valid) begin
            r_tx_count <= r_tx_count + 16'd1;
        end
    end
    assign tx_count = r_tx_count;
`else
    assign tx_count = '0;
`endif

endmodule

// File: tb/tb_modulator.sv
// Self-checking bench for modulator: randomized and directed traffic compared every cycle
// against a queue-based model of the FIFO, laser power rules and output latency.
module tb_modulator;
    import modulator_pkg::*;

    localparam int DELAY  = 2;
    localparam int DEPTH  = 4;
    localparam int WARMUP = 3;
    localparam int IDLE_T = 5;
`ifdef MODULATOR_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk;
    logic        rst;
    packet_t     in_data;
    logic        in_valid;
    logic        in_ready;
    packet_t     out_data;
    logic        out_valid;
    logic        laser_on;
    logic [15:0] tx_count;

    modulator #(
        .DELAY(DELAY), .FIFO_DEPTH(DEPTH), .WARMUP_CYCLES(WARMUP), .IDLE_TIMEOUT(IDLE_T)
    ) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .laser_on(laser_on), .tx_count(tx_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard and reference model state
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          primed = 0;
    logic [31:0] exp_q[$];
    logic [31:0] pipe_d[$];
    int          pipe_due[$];
    int          mode = 0;        // 0 off, 1 warming, 2 active
    int          warm_left = 0;
    int          idle = 0;
    logic [15:0] tx_model = '0;

    // generator state
    bit          have_pkt = 0;
    logic [31:0] pkt = '0;
    int          pkts_left = 0;
    int          prob = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pipe_d.delete();
        pipe_due.delete();
        mode = 0;
        warm_left = 0;
        idle = 0;
        tx_model = '0;
    endtask

    // One clock cycle: drive inputs, compare outputs at negedge, advance the model.
    task automatic step(input logic rst_v);
        logic        exp_ov;
        logic [31:0] exp_od;
        logic        acc;
        logic        inflight;
        logic        pop;
        @(posedge clk);
        #1;
        rst = rst_v;
        if (!have_pkt && pkts_left > 0 && $urandom_range(0, 99) < prob) begin
            have_pkt = 1;
            pkt = $urandom;
            pkts_left--;
        end
        in_valid = have_pkt;
        in_data  = have_pkt ? pkt : $urandom;
        @(negedge clk);
        exp_ov = (pipe_due.size() > 0) && (pipe_due[0] == cyc);
        exp_od = exp_ov ? pipe_d[0] : 32'd0;
        check_val("in_ready", {31'd0, in_ready}, {31'd0, rst_v && (exp_q.size() < DEPTH)});
        if (primed) begin
            check_val("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
            check_val("out_data", out_data, exp_od);
            check_val("laser_on", {31'd0, laser_on}, {31'd0, mode != 0});
            check_val("tx_count", {16'd0, tx_count}, STATS ? {16'd0, tx_model} : 32'd0);
        end
        if (!rst_v) begin
            model_reset();
            primed = 1;
        end else begin
            inflight = (pipe_due.size() > 0);
            if (exp_ov) begin
                void'(pipe_d.pop_front());
                void'(pipe_due.pop_front());
                tx_model = tx_model + 16'd1;
            end
            acc = in_valid && (exp_q.size() < DEPTH);
            pop = (mode == 2) && (exp_q.size() > 0);
            case (mode)
                0: if (acc || exp_q.size() > 0) begin mode = 1; warm_left = WARMUP; end
                1: begin
                    warm_left--;
                    if (warm_left == 0) begin mode = 2; idle = 0; end
                end
                default: begin
                    if (exp_q.size() == 0 && !acc && !inflight) begin
                        idle++;
                        if (idle == IDLE_T) begin mode = 0; idle = 0; end
                    end else begin
                        idle = 0;
                    end
                end
            endcase
            if (pop) begin
                pipe_d.push_back(exp_q.pop_front());
                pipe_due.push_back(cyc + DELAY);
            end
            if (acc) begin
                exp_q.push_back(in_data);
                have_pkt = 0;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        have_pkt = 0;
        pkts_left = 0;
        step(1'b0);
        step(1'b0);
    endtask

    task automatic run_random(input int cycles, input int p);
        prob = p;
        pkts_left = 1000000;
        for (int i = 0; i < cycles; i++) step(1'b1);
        pkts_left = 0;
    endtask

    initial begin
        rst = 1'b0;
        in_valid = 1'b0;
        in_data = '0;

        // Cold start, timeout cancel, idle shutdown and re-warm-up.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            if (k == 0 || k == 11 || k == 25) begin
                have_pkt = 1;
                pkt = 32'hA000_0000 + k;
            end
            step(1'b1);
            if (k == 0)  check_val("cold_laser_pre", {31'd0, laser_on}, 32'd0);
            if (k == 1)  check_val("cold_laser_on", {31'd0, laser_on}, 32'd1);
            if (k == 5)  check_val("cold_no_out", {31'd0, out_valid}, 32'd0);
            if (k == 6)  check_val("cold_out", out_data, 32'hA000_0000);
            if (k == 12) check_val("cancel_laser", {31'd0, laser_on}, 32'd1);
            if (k == 14) check_val("cancel_out", out_data, 32'hA000_000B);
            if (k == 19) check_val("idle_laser_on", {31'd0, laser_on}, 32'd1);
            if (k == 20) check_val("idle_laser_off", {31'd0, laser_on}, 32'd0);
            if (k == 30) check_val("rewarm_no_out", {31'd0, out_valid}, 32'd0);
            if (k == 31) check_val("rewarm_out", out_data, 32'hA000_0019);
        end

        // Backpressure: five back-to-back packets into a four-entry FIFO.
        do_reset();
        prob = 100;
        pkts_left = 5;
        for (int k = 0; k < 14; k++) begin
            step(1'b1);
            if (k == 4) check_val("bp_full_ready", {31'd0, in_ready}, 32'd0);
            if (k == 5) check_val("bp_ready_again", {31'd0, in_ready}, 32'd1);
            if (k >= 6 && k <= 10) check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
            if (k == 11) check_val("bp_out_done", {31'd0, out_valid}, 32'd0);
        end

        // Reset with three packets buffered and two in the pipeline.
        do_reset();
        prob = 100;
        pkts_left = 5;
        for (int k = 0; k < 6; k++) step(1'b1);
        pkts_left = 0;
        step(1'b0);
        step(1'b0);
        for (int k = 0; k < 12; k++) begin
            step(1'b1);
            if (k == 0) check_val("rst_ready", {31'd0, in_ready}, 32'd1);
            check_val("rst_no_out", {31'd0, out_valid}, 32'd0);
            check_val("rst_laser", {31'd0, laser_on}, 32'd0);
        end

        // Randomized traffic at several densities, with a reset in between.
        run_random(400, 70);
        run_random(400, 8);
        run_random(200, 100);
        do_reset();
        run_random(300, 30);
        run_random(60, 0);

`ifdef MODULATOR_STATS_EN
        do_reset();
        prob = 100;
        pkts_left = 65537;
        for (int k = 0; k < 65537 + 30; k++) step(1'b1);
        check_val("stats_wrap", {16'd0, tx_count}, 32'd1);
`else
        check_val("stats_tied", {16'd0, tx_count}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
